// File: rtl/segre_pkg.sv
// Shared types and dcache data-array defaults for the segre core.
// Consumed by segre_dcache_data_nway and its way storage.
package segre_pkg;

   localparam int WORD_SIZE = 32;

   localparam int DCACHE_NUM_WAYS   = 4;
   localparam int DCACHE_LANE_BYTES = 16;
   localparam int DCACHE_BEAT_BITS  = 64;

   typedef enum logic [1:0] {
      BYTE,
      HALF,
      WORD
   } memop_data_type_e;

   typedef enum logic [1:0] {
      DDA_IDLE,
      DDA_FILL,
      DDA_EVICT
   } dcache_data_state_e;

endpackage

// File: rtl/segre_dcache_data_way.sv
// One way of the dcache data array: per-byte write enables, full-line read.
// BW is 8, or 9 when a parity bit rides along with each byte.
module segre_dcache_data_way #(
   parameter  int NUM_SETS   = 16,
   parameter  int LANE_BYTES = 16,
   parameter  int BW         = 8,
   localparam int IDX_W      = $clog2(NUM_SETS),
   localparam int LW         = LANE_BYTES * BW
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      widx_i,
   input  logic [LANE_BYTES-1:0] be_i,
   input  logic [LW-1:0]         wdata_i,
   input  logic [IDX_W-1:0]      ridx_i,
   output logic [LW-1:0]         rdata_o
);

   logic [LW-1:0] mem_q [NUM_SETS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < LANE_BYTES; b++) begin
            if (be_i[b]) mem_q[widx_i][b*BW +: BW] <= wdata_i[b*BW +: BW];
         end
      end
   end

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/segre_dcache_data_nway.sv
// N-way dcache data array: CPU load/store, multi-beat refill and evict streaming.
// Optional per-byte even parity with `define DCACHE_PARITY_EN.
module segre_dcache_data_nway
   import segre_pkg::*;
#(
   parameter  int NUM_WAYS   = DCACHE_NUM_WAYS,
   parameter  int NUM_SETS   = 16,
   parameter  int LANE_BYTES = DCACHE_LANE_BYTES,
   parameter  int BEAT_BITS  = DCACHE_BEAT_BITS,
   localparam int BYTE_W     = $clog2(LANE_BYTES),
   localparam int IDX_W      = $clog2(NUM_SETS),
   localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   localparam int BEATS      = LANE_BYTES * 8 / BEAT_BITS,
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_rd_i,
   input  logic                 req_wr_i,
   output logic                 ready_o,
   input  logic [WORD_SIZE-1:0] addr_i,
   input  logic [WAY_W-1:0]     way_i,
   input  memop_data_type_e     memop_data_type_i,
   input  logic [WORD_SIZE-1:0] data_i,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 data_valid_o,
   output logic                 misalign_o,
`ifdef DCACHE_PARITY_EN
   output logic                 parity_err_o,
`endif
   input  logic                 fill_start_i,
   input  logic [WAY_W-1:0]     fill_way_i,
   input  logic [IDX_W-1:0]     fill_index_i,
   input  logic                 fill_valid_i,
   input  logic [BEAT_BITS-1:0] fill_data_i,
   output logic                 fill_done_o,
   input  logic                 evict_start_i,
   output logic                 evict_valid_o,
   output logic [BEAT_BITS-1:0] evict_data_o,
   input  logic                 evict_ready_i
);

`ifdef DCACHE_PARITY_EN
   localparam int BW = 9;
`else
   localparam int BW = 8;
`endif
   localparam int LW = LANE_BYTES * BW;
   localparam int BB = BEAT_BITS / 8;

   function automatic logic [BW-1:0] enc(input logic [7:0] d);
`ifdef DCACHE_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   dcache_data_state_e   state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     sel_idx_q;
   logic [WAY_W-1:0]     sel_way_q;

   logic                 idle, misal, cpu_acc, start_acc;
   logic                 st_go, ld_go, fill_we, ev_hs, last;
   logic [IDX_W-1:0]     index, rd_idx, wr_idx;
   logic [BYTE_W-1:0]    offset;
   logic [WAY_W-1:0]     rd_way, wr_way;
   logic                 wr_en;
   logic [LANE_BYTES-1:0] be;
   logic [LW-1:0]        wdata, rline;
   logic [LW-1:0]        rdata [NUM_WAYS];
   logic [WORD_SIZE-1:0] ld_word;
   logic                 ld_perr, ev_perr;
   int                   nb;
   logic                 unused_addr;

   assign index  = addr_i[IDX_W+BYTE_W-1:BYTE_W];
   assign offset = addr_i[BYTE_W-1:0];
   assign unused_addr = ^addr_i[WORD_SIZE-1:IDX_W+BYTE_W];

   assign idle      = (state_q == DDA_IDLE);
   assign ready_o   = idle;
   assign misal     = (memop_data_type_i == HALF && offset[0]) ||
                      (memop_data_type_i == WORD && offset[1:0] != 2'b00);
   assign start_acc = idle && (evict_start_i || fill_start_i);
   assign cpu_acc   = idle && !start_acc && (req_rd_i || req_wr_i);
   assign st_go     = cpu_acc && req_wr_i && !misal;
   assign ld_go     = cpu_acc && req_rd_i && !req_wr_i && !misal;
   assign fill_we   = (state_q == DDA_FILL) && fill_valid_i;
   assign ev_hs     = (state_q == DDA_EVICT) && evict_ready_i;
   assign last      = (cnt_q == CNT_W'(BEATS - 1));

   always_comb begin
      nb = 1;
      if (memop_data_type_i == WORD) nb = 4;
      else if (memop_data_type_i == HALF) nb = 2;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= DDA_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         DDA_IDLE: begin
            if (evict_start_i) state_d = DDA_EVICT;
            else if (fill_start_i) state_d = DDA_FILL;
         end
         DDA_FILL, DDA_EVICT: begin
            if (fill_we || ev_hs) begin
               if (last) begin
                  cnt_d   = '0;
                  state_d = DDA_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = DDA_IDLE;
      endcase
   end

   // Refill beats and CPU stores share the single write port; FSM keeps them exclusive.
   always_comb begin
      logic [BYTE_W-1:0] rel;
      wr_en  = 1'b0;
      wr_way = way_i;
      wr_idx = index;
      be     = '0;
      wdata  = '0;
      rel    = '0;
      if (fill_we) begin
         wr_en  = 1'b1;
         wr_way = sel_way_q;
         wr_idx = sel_idx_q;
         for (int b = 0; b < LANE_BYTES; b++) begin
            if (b / BB == int'(cnt_q)) begin
               be[b] = 1'b1;
               wdata[b*BW +: BW] = enc(fill_data_i[(b%BB)*8 +: 8]);
            end
         end
      end else if (st_go) begin
         wr_en = 1'b1;
         for (int b = 0; b < LANE_BYTES; b++) begin
            rel = BYTE_W'(b) - offset;
            if (int'(rel) < nb) begin
               be[b] = 1'b1;
               wdata[b*BW +: BW] = enc(data_i[rel[1:0]*8 +: 8]);
            end
         end
      end
   end

   assign rd_way = idle ? way_i : sel_way_q;
   assign rd_idx = idle ? index : sel_idx_q;
   assign rline  = rdata[rd_way];

   for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
      segre_dcache_data_way #(
         .NUM_SETS   (NUM_SETS),
         .LANE_BYTES (LANE_BYTES),
         .BW         (BW)
      ) u_way (
         .clk_i   (clk_i),
         .we_i    (wr_en && (wr_way == WAY_W'(g))),
         .widx_i  (wr_idx),
         .be_i    (be),
         .wdata_i (wdata),
         .ridx_i  (rd_idx),
         .rdata_o (rdata[g])
      );
   end

   always_comb begin
      logic [BYTE_W-1:0] ob;
      logic [BW-1:0]     bv;
      ld_word = '0;
      ld_perr = 1'b0;
      ob      = '0;
      bv      = '0;
      for (int k = 0; k < 4; k++) begin
         ob = offset + BYTE_W'(k);
         bv = rline[ob*BW +: BW];
         if (k < nb) begin
            ld_word[k*8 +: 8] = bv[7:0];
            ld_perr = ld_perr | (^bv);
         end
      end
   end

   always_comb begin
      logic [BW-1:0] bv;
      evict_data_o = '0;
      ev_perr      = 1'b0;
      bv           = '0;
      if (state_q == DDA_EVICT) begin
         for (int j = 0; j < BB; j++) begin
            bv = rline[(int'(cnt_q)*BB + j)*BW +: BW];
            evict_data_o[j*8 +: 8] = bv[7:0];
            ev_perr = ev_perr | (^bv);
         end
      end
   end

   assign evict_valid_o = (state_q == DDA_EVICT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sel_idx_q    <= '0;
         sel_way_q    <= '0;
         data_o       <= '0;
         data_valid_o <= 1'b0;
         misalign_o   <= 1'b0;
         fill_done_o  <= 1'b0;
      end else begin
         if (start_acc) begin
            sel_idx_q <= fill_index_i;
            sel_way_q <= fill_way_i;
         end
         // Load data stays visible until the array accepts another operation.
         if (cpu_acc || start_acc) data_valid_o <= ld_go;
         if (ld_go) data_o <= ld_word;
         misalign_o  <= cpu_acc && misal;
         fill_done_o <= fill_we && last;
      end
   end

`ifdef DCACHE_PARITY_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) parity_err_o <= 1'b0;
      else parity_err_o <= (ld_go && ld_perr) || (ev_hs && ev_perr);
   end
`else
   logic unused_perr;
   assign unused_perr = ld_perr ^ ev_perr;
`endif

endmodule
